// File: rtl/alu_pkg.sv
// Shared definitions for the arbitrated ALU: opcodes, FSM states, flag bit positions.
// Latency: none (declarations only).
// Backpressure: not applicable.
package alu_pkg;

    // ALU opcodes
    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_NOT = 3'b010;
    localparam logic [2:0] OP_AND = 3'b011;
    localparam logic [2:0] OP_OR  = 3'b100;
    localparam logic [2:0] OP_XOR = 3'b101;
    localparam logic [2:0] OP_SLT = 3'b110;
    localparam logic [2:0] OP_EQ  = 3'b111;

    // Control FSM encoding
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    // Bit positions inside rsp_flags = {overflow, carry, zero}
    localparam int FLAG_Z  = 0;
    localparam int FLAG_C  = 1;
    localparam int FLAG_OV = 2;

endpackage

// File: rtl/alu_core.sv
// Purely combinational ALU: op/a/b -> y plus overflow/carry/zero.
// Latency: 0 cycles (combinational).
// Backpressure: none; the caller registers the outputs when it is ready.
import alu_pkg::*;

module alu_core #(
    parameter int W = 4
) (
    input  logic [2:0]   op_i,
    input  logic [W-1:0] a_i,
    input  logic [W-1:0] b_i,
    output logic [W-1:0] y_o,
    output logic         overflow_o,
    output logic         carry_o,
    output logic         zero_o
);

    logic [W-1:0] b_eff;
    logic [W:0]   sum;

    // Shared adder: every opcode except add runs a + ~b + 1 so sub/slt reuse it
    always_comb begin
        b_eff = (op_i == OP_ADD) ? b_i : ~b_i;
        sum   = {1'b0, a_i} + {1'b0, b_eff} + {{W{1'b0}}, (op_i != OP_ADD)};
    end

    // Result select; flags other than zero only carry meaning for add/sub
    always_comb begin
        y_o        = '0;
        overflow_o = 1'b0;
        carry_o    = 1'b0;
        case (op_i)
            OP_ADD, OP_SUB: begin
                y_o        = sum[W-1:0];
                carry_o    = sum[W];
                // Overflow when both adder inputs share a sign the result does not
                overflow_o = (a_i[W-1] == b_eff[W-1]) && (sum[W-1] != a_i[W-1]);
            end
            OP_NOT:  y_o = ~a_i;
            OP_AND:  y_o = a_i & b_i;
            OP_OR:   y_o = a_i | b_i;
            OP_XOR:  y_o = a_i ^ b_i;
            OP_SLT:  y_o = {{(W-1){1'b0}}, sum[W-1]};
            OP_EQ:   y_o = {{(W-1){1'b0}}, (a_i == b_i)};
            default: y_o = '0;
        endcase
        zero_o = (y_o == '0);
    end

endmodule

// File: rtl/alu_arbiter.sv
// Two-requester round-robin front end sharing one ALU, with a registered response.
// Latency: accept in cycle N -> rsp_valid in N+2; one operation in flight, accepts >= 3 cycles apart.
// Backpressure: the response holds stable until rsp_ready; requesters are only accepted in IDLE.
import alu_pkg::*;

module alu_arbiter #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         req0_valid,
    input  logic         req1_valid,
    output logic         req0_ready,
    output logic         req1_ready,
    input  logic [2:0]   req0_op,
    input  logic [2:0]   req1_op,
    input  logic [W-1:0] req0_a,
    input  logic [W-1:0] req0_b,
    input  logic [W-1:0] req1_a,
    input  logic [W-1:0] req1_b,
    output logic         rsp_valid,
    input  logic         rsp_ready,
    output logic         rsp_id,
    output logic [W-1:0] rsp_y,
    output logic [2:0]   rsp_flags
);

    state_t       state_q;
    logic         last_q;       // requester granted most recently
    logic [2:0]   op_q;
    logic [W-1:0] a_q;
    logic [W-1:0] b_q;
    logic         id_q;
    logic         rsp_valid_q;
    logic         rsp_id_q;
    logic [W-1:0] rsp_y_q;
    logic [2:0]   rsp_flags_q;

    logic         grant0;
    logic         grant1;
    logic [2:0]   op_d;
    logic [W-1:0] a_d;
    logic [W-1:0] b_d;
    logic         id_d;

    logic [W-1:0] alu_y;
    logic         alu_ov;
    logic         alu_c;
    logic         alu_z;
    logic [2:0]   flags_d;

    // Round-robin grant: a lone requester wins, a tie goes to the one not granted last
    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
        if (rst_n && (state_q == ST_IDLE)) begin
            if (req0_valid && (!req1_valid || last_q)) begin
                grant0 = 1'b1;
            end else if (req1_valid) begin
                grant1 = 1'b1;
            end
        end
    end

    assign req0_ready = grant0;
    assign req1_ready = grant1;

    // Operand mux for the winning requester
    always_comb begin
        op_d = grant1 ? req1_op : req0_op;
        a_d  = grant1 ? req1_a  : req0_a;
        b_d  = grant1 ? req1_b  : req0_b;
        id_d = grant1;
    end

    // ALU sees only the captured operands, never the live request buses
    alu_core #(
        .W (W)
    ) u_alu_core (
        .op_i       (op_q),
        .a_i        (a_q),
        .b_i        (b_q),
        .y_o        (alu_y),
        .overflow_o (alu_ov),
        .carry_o    (alu_c),
        .zero_o     (alu_z)
    );

    // Pack ALU flags into the response layout
    always_comb begin
        flags_d          = '0;
        flags_d[FLAG_OV] = alu_ov;
        flags_d[FLAG_C]  = alu_c;
        flags_d[FLAG_Z]  = alu_z;
    end

    // Control FSM with registered capture and response outputs
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            last_q      <= 1'b1;
            op_q        <= '0;
            a_q         <= '0;
            b_q         <= '0;
            id_q        <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= 1'b0;
            rsp_y_q     <= '0;
            rsp_flags_q <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (grant0 || grant1) begin
                        op_q    <= op_d;
                        a_q     <= a_d;
                        b_q     <= b_d;
                        id_q    <= id_d;
                        last_q  <= id_d;
                        state_q <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    rsp_y_q     <= alu_y;
                    rsp_flags_q <= flags_d;
                    rsp_id_q    <= id_q;
                    rsp_valid_q <= 1'b1;
                    state_q     <= ST_RESP;
                end
                ST_RESP: begin
                    if (rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        state_q     <= ST_IDLE;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_id    = rsp_id_q;
    assign rsp_y     = rsp_y_q;
    assign rsp_flags = rsp_flags_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter with a request queue per port and a response scoreboard.
// Latency: checks accept -> rsp_valid spacing of two cycles.
// Backpressure: exercises rsp_ready stalls and request ties.
module tb_alu_arbiter;
    import alu_pkg::*;

    localparam int W = 4;
    localparam int M = 1 << W;
    localparam int H = M / 2;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         req0_valid = 1'b0, req1_valid = 1'b0;
    logic         req0_ready, req1_ready;
    logic [2:0]   req0_op = '0, req1_op = '0;
    logic [W-1:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
    logic         rsp_valid;
    logic         rsp_ready = 1'b1;
    logic         rsp_id;
    logic [W-1:0] rsp_y;
    logic [2:0]   rsp_flags;

    alu_arbiter #(.W(W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req0_valid (req0_valid),
        .req1_valid (req1_valid),
        .req0_ready (req0_ready),
        .req1_ready (req1_ready),
        .req0_op    (req0_op),
        .req1_op    (req1_op),
        .req0_a     (req0_a),
        .req0_b     (req0_b),
        .req1_a     (req1_a),
        .req1_b     (req1_b),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_id     (rsp_id),
        .rsp_y      (rsp_y),
        .rsp_flags  (rsp_flags)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct { logic [2:0] op; logic [W-1:0] a; logic [W-1:0] b; } req_t;
    typedef struct { logic id; logic [W-1:0] y; logic [2:0] flags; int acc; } exp_t;

    req_t q0[$];
    req_t q1[$];
    exp_t sb[$];
    int   got_ids[$];

    int tests = 0;
    int fails = 0;

    logic         last_m = 1'b1;
    int           stall_left = 0;
    bit           stalling = 1'b0;
    logic         prev_v = 1'b0;
    logic [W-1:0] snap_y = '0, keep_y = '0;
    logic [2:0]   snap_f = '0, keep_f = '0;
    logic         snap_id = 1'b0, keep_id = 1'b0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference ALU written from the opcode table using plain integer arithmetic
    function automatic exp_t model(input logic id, input req_t r, input int acc);
        exp_t e;
        int ua, ub, sa, sbv, s, y;
        bit ov, c;
        ua = int'(r.a);
        ub = int'(r.b);
        sa  = (ua >= H) ? ua - M : ua;
        sbv = (ub >= H) ? ub - M : ub;
        ov = 1'b0; c = 1'b0; y = 0; s = 0;
        case (r.op)
            OP_ADD: begin s = ua + ub; y = s % M; c = (s >= M); ov = (sa + sbv >= H) || (sa + sbv < -H); end
            OP_SUB: begin s = ua + (M - 1 - ub) + 1; y = s % M; c = (s >= M); ov = (sa - sbv >= H) || (sa - sbv < -H); end
            OP_NOT: y = M - 1 - ua;
            OP_AND: y = int'(r.a & r.b);
            OP_OR:  y = int'(r.a | r.b);
            OP_XOR: y = int'(r.a ^ r.b);
            OP_SLT: y = (((ua - ub + M) % M) >= H) ? 1 : 0;
            OP_EQ:  y = (ua == ub) ? 1 : 0;
            default: y = 0;
        endcase
        e.id    = id;
        e.y     = y[W-1:0];
        e.flags = {ov, c, (y == 0)};
        e.acc   = acc;
        return e;
    endfunction

    // One cycle: drive at negedge, observe 1 time unit later
    task automatic step(output bit granted);
        exp_t e;
        logic g;
        granted = 1'b0;
        @(negedge clk);
        req0_valid = (q0.size() > 0);
        if (q0.size() > 0) begin req0_op = q0[0].op; req0_a = q0[0].a; req0_b = q0[0].b; end
        req1_valid = (q1.size() > 0);
        if (q1.size() > 0) begin req1_op = q1[0].op; req1_a = q1[0].a; req1_b = q1[0].b; end
        rsp_ready = !(rsp_valid && stall_left > 0);
        #1;
        if (rsp_valid && !prev_v) begin
            if (sb.size() == 0) chk("unexpected_rsp", 1, 0);
            else chk("latency", cyc, sb[0].acc + 2);
        end
        if (!rsp_valid) begin
            chk("hold_y", rsp_y, keep_y);
            chk("hold_flags", rsp_flags, keep_f);
            chk("hold_id", rsp_id, keep_id);
        end
        if (rsp_valid && !rsp_ready) begin
            if (stalling) begin
                chk("stall_y", rsp_y, snap_y);
                chk("stall_flags", rsp_flags, snap_f);
                chk("stall_id", rsp_id, snap_id);
            end
            chk("stall_rdy0", req0_ready, 0);
            chk("stall_rdy1", req1_ready, 0);
            snap_y = rsp_y; snap_f = rsp_flags; snap_id = rsp_id;
            stalling = 1'b1;
            stall_left--;
        end
        if (rsp_valid && rsp_ready) begin
            stalling = 1'b0;
            if (sb.size() == 0) chk("rsp_without_req", 1, 0);
            else begin
                e = sb.pop_front();
                chk("rsp_id", rsp_id, e.id);
                chk("rsp_y", rsp_y, e.y);
                chk("rsp_flags", rsp_flags, e.flags);
                got_ids.push_back(int'(rsp_id));
            end
            keep_y = rsp_y; keep_f = rsp_flags; keep_id = rsp_id;
        end
        if (req0_ready || req1_ready) begin
            if (!req0_valid && !req1_valid) chk("ready_without_valid", 1, 0);
            else begin
                g = (req0_valid && req1_valid) ? ~last_m : !req0_valid;
                chk("grant0", req0_ready, !g);
                chk("grant1", req1_ready, g);
                if (g) e = model(1'b1, q1.pop_front(), cyc);
                else   e = model(1'b0, q0.pop_front(), cyc);
                sb.push_back(e);
                last_m = g;
                granted = 1'b1;
            end
        end
        prev_v = rsp_valid;
    endtask

    task automatic run(input int budget);
        bit g;
        int n;
        n = 0;
        while ((q0.size() > 0 || q1.size() > 0 || sb.size() > 0 || rsp_valid) && n < budget) begin
            step(g);
            n++;
        end
        chk("run_done", (q0.size() == 0 && q1.size() == 0 && sb.size() == 0), 1);
        q0.delete(); q1.delete(); sb.delete();
        req0_valid = 1'b0;
        req1_valid = 1'b0;
    endtask

    task automatic clear_model();
        sb.delete();
        last_m = 1'b1; prev_v = 1'b0; stalling = 1'b0; stall_left = 0;
        keep_y = '0; keep_f = '0; keep_id = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0; req0_valid = 1'b1; req1_valid = 1'b1; rsp_ready = 1'b0;
        repeat (2) begin
            @(negedge clk);
            #1;
            chk("rst_rdy0", req0_ready, 0);
            chk("rst_rdy1", req1_ready, 0);
            chk("rst_valid", rsp_valid, 0);
        end
        chk("rst_y", rsp_y, 0);
        chk("rst_flags", rsp_flags, 0);
        chk("rst_id", rsp_id, 0);
        rst_n = 1'b1; req0_valid = 1'b0; req1_valid = 1'b0; rsp_ready = 1'b1;
        clear_model();
    endtask

    initial begin
        bit g;
        int n;

        // Reset state
        do_reset();

        // Single add with signed overflow
        q0.push_back('{op: OP_ADD, a: 4'd7, b: 4'd1});
        run(40);

        // Tie straight after reset: req0 wins first
        do_reset();
        got_ids.delete();
        q0.push_back('{op: OP_SUB, a: 4'd3, b: 4'd3});
        q1.push_back('{op: OP_AND, a: 4'hF, b: 4'hA});
        run(40);
        chk("tie_count", got_ids.size(), 2);
        if (got_ids.size() == 2) begin
            chk("tie_first", got_ids[0], 0);
            chk("tie_second", got_ids[1], 1);
        end

        // Continuous contention alternates grants
        got_ids.delete();
        q0.push_back('{op: OP_XOR, a: 4'd5, b: 4'd3});
        q0.push_back('{op: OP_OR,  a: 4'd8, b: 4'd1});
        q1.push_back('{op: OP_NOT, a: 4'd0, b: 4'd0});
        q1.push_back('{op: OP_ADD, a: 4'hF, b: 4'd1});
        run(60);
        chk("rr_count", got_ids.size(), 4);
        for (int i = 0; i < 4; i++) begin
            if (i < got_ids.size()) chk("rr_seq", got_ids[i], i % 2);
        end

        // Compare opcodes and a signed-overflow subtract
        q0.push_back('{op: OP_SLT, a: 4'd2, b: 4'd5});
        q0.push_back('{op: OP_EQ,  a: 4'd9, b: 4'd9});
        q0.push_back('{op: OP_EQ,  a: 4'd9, b: 4'd8});
        q1.push_back('{op: OP_SUB, a: 4'd8, b: 4'd1});
        q1.push_back('{op: OP_SLT, a: 4'd5, b: 4'd2});
        run(80);

        // Response backpressure with the other requester waiting
        stall_left = 5;
        q0.push_back('{op: OP_ADD, a: 4'd3, b: 4'd4});
        q1.push_back('{op: OP_AND, a: 4'hC, b: 4'h6});
        run(60);
        chk("stall_consumed", stall_left, 0);

        // Reset while an operation is in EXEC
        q0.push_back('{op: OP_ADD, a: 4'd5, b: 4'd5});
        g = 1'b0;
        n = 0;
        while (!g && n < 10) begin
            step(g);
            n++;
        end
        chk("grant_before_rst", g, 1);
        @(negedge clk);
        rst_n = 1'b0; req0_valid = 1'b1; req1_valid = 1'b1;
        @(negedge clk);
        #1;
        chk("exec_rst_valid", rsp_valid, 0);
        chk("exec_rst_rdy0", req0_ready, 0);
        chk("exec_rst_rdy1", req1_ready, 0);
        rst_n = 1'b1; req0_valid = 1'b0; req1_valid = 1'b0;
        q0.delete(); q1.delete();
        clear_model();
        repeat (4) step(g);
        got_ids.delete();
        q0.push_back('{op: OP_OR,  a: 4'd1, b: 4'd2});
        q1.push_back('{op: OP_XOR, a: 4'd6, b: 4'd6});
        run(40);
        chk("post_rst_count", got_ids.size(), 2);
        if (got_ids.size() > 0) chk("post_rst_first", got_ids[0], 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 SHALL have parameter W, default 4, operand/result width.
REQ-002 SHALL have port clk  input  1  rising-edge clock.
REQ-003 SHALL have port rst_n  input  1  synchronous, active-low reset.
REQ-004 SHALL have ports req0_valid / req1_valid  input  1  requester n has an operation pending.
REQ-005 SHALL have ports req0_ready / req1_ready  output  1  operation of requester n accepted this cycle.
REQ-006 SHALL have ports req0_op / req1_op  input  3  ALU opcode.
REQ-007 SHALL have ports req0_a, req0_b / req1_a, req1_b  input  W  operands.
REQ-008 SHALL have port rsp_valid  output  1  result available.
REQ-009 SHALL have port rsp_ready  input  1  consumer accepts result.
REQ-010 SHALL have port rsp_id  output  1  requester that owns the result.
REQ-011 SHALL have port rsp_y  output  W  result.
REQ-012 SHALL have port rsp_flags  output  3  {overflow, carry, zero}.

Function
REQ-013 SHALL decode opcodes as: 000 add, 001 sub (a + ~b + 1), 010 ~a, 011 a&b, 100 a|b, 101 a^b, 110 y = sign bit of (a-b) zero-extended, 111 y = (a==b).
REQ-014 SHALL, for add/sub, set overflow = two's-complement overflow and carry = adder carry-out (sub: carry=1 means no borrow).
REQ-015 SHALL, for all other opcodes, force overflow=0 and carry=0.
REQ-016 SHALL set zero = (y==0) for every opcode.
REQ-017 SHALL implement FSM IDLE -> EXEC -> RESP -> IDLE.
REQ-018 IDLE: if any reqN_valid, SHALL assert reqN_ready for exactly one granted requester (combinational, same cycle), capture op/a/b/id, and move to EXEC; otherwise SHALL stay in IDLE.
REQ-019 SHALL assert reqN_ready only in IDLE, and only together with reqN_valid.
REQ-020 Arbitration: if one requester is valid, SHALL grant it; if both are valid, SHALL grant the one not granted last (round-robin).
REQ-021 SHALL update the last-grant pointer on every grant.
REQ-022 EXEC: SHALL register ALU result and flags into rsp_y / rsp_flags / rsp_id, then move to RESP.
REQ-023 RESP: SHALL hold rsp_valid=1 with rsp_* stable until rsp_ready=1; in that cycle SHALL move to IDLE.
REQ-024 Latency: for an accept in cycle N, rsp_valid SHALL first be high in cycle N+2; minimum spacing between accepts is 3 cycles.
REQ-025 SHALL ignore reqN_valid changes outside IDLE; a request that drops before grant is lost without error.
REQ-026 SHALL keep rsp_y / rsp_flags / rsp_id unchanged while rsp_valid=0 after a handshake (last value retained).

Reset
REQ-027 When rst_n=0 at a clock edge, SHALL go to IDLE with rsp_valid=0, rsp_y=0, rsp_flags=0, rsp_id=0, last-grant=1 (req0 wins first tie).
REQ-028 While rst_n=0, req0_ready and req1_ready SHALL be 0.
REQ-029 Reset in EXEC or RESP SHALL discard the in-flight operation with no response.

Structure
REQ-030 SHALL place opcode constants, FSM state encoding and flag bit indices in shared package alu_pkg.
REQ-031 SHALL instantiate one combinational sub-module alu_core (op, a, b -> y, overflow, carry, zero), fed from captured registers only.

Verification
REQ-032 req0 add a=7, b=1, rsp_ready=1 -> rsp_valid at N+2, y=8, flags={1,0,0}, id=0.
REQ-033 After reset, both valid in the same cycle: req0 sub 3-3, req1 and F&A -> first rsp id=0, y=0, flags={0,1,1}; second rsp id=1, y=A, flags={0,0,0}.
REQ-034 Both valid continuously for 4 ops -> rsp_id sequence 0,1,0,1.
REQ-035 op 110 a=2, b=5 -> y=1; op 111 a=9, b=9 -> y=1; op 111 a=9, b=8 -> y=0, zero=1.
REQ-036 rsp_ready low for 5 cycles in RESP -> rsp_* stable, both readies 0, response completes on first rsp_ready=1.
REQ-037 rst_n low in EXEC -> next cycle rsp_valid=0; after release, tie grants req0 first.
